password_lock_ctrl: RTL and testbench

Parametrised successor to the team's 4-bit password lock. It adds configurable password width and attempt limit, a stored password that can be reprogrammed, explicit re-locking and a registered status output. It sits between the keypad/entry front end (which supplies `passin` and a one-cycle `enter` strobe) and the door actuator and alarm drivers.

---
 rtl/pwlock_pkg.sv | 15 +
 rtl/pwlock_lockout_timer.sv | 38 +++
 rtl/password_lock_ctrl.sv | 134 +++++++++++++
 tb/tb_password_lock_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwlock_pkg.sv
// Shared types and helpers for the parametrised password lock controller.
package pwlock_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        OPEN   = 2'd1,
        ALARM  = 2'd2
    } pwlock_state_t;

    // Width of the wrong-attempt counter: must hold the value MAX_TRY.
    function automatic int cnt_width(input int max_try);
        return (max_try < 1) ? 1 : $clog2(max_try + 1);
    endfunction

endpackage

// File: rtl/pwlock_lockout_timer.sv
// Alarm lockout timer: armed by a one-cycle start, flags done on its last cycle.
// Only instantiated when PWLOCK_LOCKOUT_TIMER_EN is defined.
module pwlock_lockout_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic done
);

    localparam int TW = $clog2(LOCK_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(LOCK_CYCLES - 1);

    logic          active;
    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
        end else if (active) begin
            if (count == LAST) begin
                active <= 1'b0;
                count  <= '0;
            end else begin
                count <= count + TW'(1);
            end
        end
    end

    // High during the final ALARM cycle, so the FSM leaves on the next edge.
    assign done = active && (count == LAST);

endmodule

// File: rtl/password_lock_ctrl.sv
// Password lock controller: reprogrammable password, attempt limit, registered outputs.
// Optional alarm auto-release is enabled by defining PWLOCK_LOCKOUT_TIMER_EN.
module password_lock_ctrl
    import pwlock_pkg::*;
#(
    parameter int              PW_W        = 4,
    parameter int              MAX_TRY     = 3,
    parameter logic [PW_W-1:0] RESET_PASS  = PW_W'(4'hA),
    parameter int              LOCK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [PW_W-1:0]               passin,
    input  logic                          enter,
    input  logic                          prog,
    input  logic                          lock,
    output logic                          access,
    output logic                          alarm,
    output logic                          fail,
    output logic [cnt_width(MAX_TRY)-1:0] cnt,
    output logic [1:0]                    state
);

    localparam int CW = cnt_width(MAX_TRY);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_TRY - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_TRY);

    if (PW_W < 1) begin : g_bad_pw_w
        $error("password_lock_ctrl: PW_W must be >= 1");
    end
    if (MAX_TRY < 1) begin : g_bad_max_try
        $error("password_lock_ctrl: MAX_TRY must be >= 1");
    end
    if (LOCK_CYCLES < 2) begin : g_bad_lock_cycles
        $error("password_lock_ctrl: LOCK_CYCLES must be >= 2");
    end

    pwlock_state_t   state_q, state_d;
    logic [PW_W-1:0] pass_q, pass_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            access_d, alarm_d, fail_d;

`ifdef PWLOCK_LOCKOUT_TIMER_EN
    logic timer_start;
    logic timer_done;

    assign timer_start = (state_d == ALARM) && (state_q != ALARM);

    pwlock_lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lockout_timer (
        .clk  (clk),
        .rstn (rstn),
        .start(timer_start),
        .done (timer_done)
    );
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOCKED;
            pass_q  <= RESET_PASS;
            cnt_q   <= '0;
            access  <= 1'b0;
            alarm   <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            access  <= access_d;
            alarm   <= alarm_d;
            fail    <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        fail_d  = 1'b0;
        case (state_q)
            LOCKED: begin
                if (enter) begin
                    if (passin == pass_q) begin
                        state_d = OPEN;
                        cnt_d   = '0;
                    end else begin
                        fail_d = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = CNT_MAX;
                            state_d = ALARM;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            OPEN: begin
                // A re-lock request drops any enter on the same cycle.
                if (lock) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end else if (enter && prog) begin
                    pass_d = passin;
                end
            end
            ALARM: begin
`ifdef PWLOCK_LOCKOUT_TIMER_EN
                if (timer_done) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = LOCKED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: registered door/alarm levels follow the next state
    always_comb begin
        access_d = (state_d == OPEN);
        alarm_d  = (state_d == ALARM);
    end

    assign cnt   = cnt_q;
    assign state = state_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Self-checking bench for password_lock_ctrl: vector table, corner sequences, random vs model.
module tb_password_lock_ctrl;

    localparam int LOCK_CYCLES = 8;
    localparam int MAX_TRY     = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] passin;
    logic       enter, prog, lock;
    logic       access, alarm, fail;
    logic [1:0] cnt;
    logic [1:0] state;

    logic       access1, alarm1, fail1;
    logic [0:0] cnt1;
    logic [1:0] state1;

    int n_cmp = 0;
    int n_err = 0;

    password_lock_ctrl #(
        .PW_W(4), .MAX_TRY(MAX_TRY), .RESET_PASS(4'hA), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .passin(passin), .enter(enter), .prog(prog), .lock(lock),
        .access(access), .alarm(alarm), .fail(fail), .cnt(cnt), .state(state)
    );

    password_lock_ctrl #(
        .PW_W(4), .MAX_TRY(1), .RESET_PASS(4'hA), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut1 (
        .clk(clk), .rstn(rstn), .passin(passin), .enter(enter), .prog(prog), .lock(lock),
        .access(access1), .alarm(alarm1), .fail(fail1), .cnt(cnt1), .state(state1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (mode: 0 locked, 1 open, 2 alarm)
    int m_mode, m_pass, m_wrong, m_age, m_fail;

    task automatic model_reset();
        m_mode = 0; m_pass = 'hA; m_wrong = 0; m_age = 0; m_fail = 0;
    endtask

    task automatic model_step(input int p, input int e, input int pr, input int lk);
        m_fail = 0;
        if (m_mode == 0) begin
            if (e != 0) begin
                if (p == m_pass) begin
                    m_mode = 1; m_wrong = 0;
                end else begin
                    m_fail = 1;
                    m_wrong = m_wrong + 1;
                    if (m_wrong >= MAX_TRY) begin
                        m_mode = 2; m_age = 0;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (lk != 0) begin
                m_mode = 0; m_wrong = 0;
            end else if (e != 0 && pr != 0) begin
                m_pass = p;
            end
        end else begin
`ifdef PWLOCK_LOCKOUT_TIMER_EN
            m_age = m_age + 1;
            if (m_age == LOCK_CYCLES) begin
                m_mode = 0; m_wrong = 0;
            end
`endif
        end
    endtask

    // ---------------- checking
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("access", int'(access), (m_mode == 1) ? 1 : 0);
        chk("alarm",  int'(alarm),  (m_mode == 2) ? 1 : 0);
        chk("fail",   int'(fail),   m_fail);
        chk("cnt",    int'(cnt),    m_wrong);
        chk("state",  int'(state),  m_mode);
    endtask

    // ---------------- drivers
    task automatic cycle(input logic [3:0] p, input logic e, input logic pr, input logic lk);
        passin = p; enter = e; prog = pr; lock = lk;
        model_step(int'(p), int'(e), int'(pr), int'(lk));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        passin = 4'h0; enter = 1'b0; prog = 1'b0; lock = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] p;
        logic       e, pr, lk;
        logic       x_access, x_alarm, x_fail;
        logic [1:0] x_cnt, x_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] p, input logic e, input logic pr, input logic lk,
                       input logic xa, input logic xal, input logic xf,
                       input logic [1:0] xc, input logic [1:0] xs);
        vec_t v;
        v.p = p; v.e = e; v.pr = pr; v.lk = lk;
        v.x_access = xa; v.x_alarm = xal; v.x_fail = xf; v.x_cnt = xc; v.x_state = xs;
        vecs.push_back(v);
    endtask

    initial begin
        int alarm_cycles;
        logic [3:0] rp;

        rstn = 1'b0; passin = 4'h0; enter = 1'b0; prog = 1'b0; lock = 1'b0;
        //  p     e  pr lk   acc al fail cnt st
        add(4'hA, 1, 0, 0,   1, 0, 0, 0, 1);  // reset-then-correct
        add(4'h3, 1, 0, 0,   1, 0, 0, 0, 1);  // enter without prog in OPEN: no effect
        add(4'h6, 1, 1, 0,   1, 0, 0, 0, 1);  // reprogram to 6
        add(4'h0, 0, 0, 1,   0, 0, 0, 0, 0);  // lock
        add(4'hA, 1, 0, 0,   0, 0, 1, 1, 0);  // old password now wrong
        add(4'h6, 1, 0, 0,   1, 0, 0, 0, 1);  // new password opens
        add(4'h9, 1, 1, 1,   0, 0, 0, 0, 0);  // lock beats prog+enter
        add(4'h9, 1, 0, 0,   0, 0, 1, 1, 0);  // 9 was not stored
        add(4'h6, 1, 0, 0,   1, 0, 0, 0, 1);
        add(4'hA, 1, 1, 0,   1, 0, 0, 0, 1);  // back to A
        add(4'h0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(4'h3, 1, 0, 0,   0, 0, 1, 1, 0);  // wrong x2 then correct
        add(4'h5, 1, 0, 0,   0, 0, 1, 2, 0);
        add(4'hA, 1, 0, 0,   1, 0, 0, 0, 1);
        add(4'h0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(4'hA, 0, 0, 0,   0, 0, 0, 0, 0);  // no strobe, no attempt
        add(4'h1, 1, 0, 0,   0, 0, 1, 1, 0);  // three wrong -> alarm
        add(4'h2, 1, 0, 0,   0, 0, 1, 2, 0);
        add(4'h4, 1, 0, 0,   0, 1, 1, 3, 2);
        add(4'hA, 1, 0, 0,   0, 1, 0, 3, 2);  // correct password ignored in ALARM
        add(4'hA, 1, 1, 1,   0, 1, 0, 3, 2);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].p, vecs[i].e, vecs[i].pr, vecs[i].lk);
            chk($sformatf("vec%0d.access", i), int'(access), int'(vecs[i].x_access));
            chk($sformatf("vec%0d.alarm",  i), int'(alarm),  int'(vecs[i].x_alarm));
            chk($sformatf("vec%0d.fail",   i), int'(fail),   int'(vecs[i].x_fail));
            chk($sformatf("vec%0d.cnt",    i), int'(cnt),    int'(vecs[i].x_cnt));
            chk($sformatf("vec%0d.state",  i), int'(state),  int'(vecs[i].x_state));
        end

`ifdef PWLOCK_LOCKOUT_TIMER_EN
        // ALARM was shown for the last three vectors; count the rest (bounded).
        alarm_cycles = 3;
        for (int i = 0; i < 50; i++) begin
            cycle(4'h0, 0, 0, 0);
            if (alarm) alarm_cycles++;
            else break;
        end
        chk("alarm_len", alarm_cycles, LOCK_CYCLES);
        chk("timeout.state", int'(state), 0);
        chk("timeout.cnt", int'(cnt), 0);
        cycle(4'hA, 1, 0, 0);
        chk("timeout.reopen", int'(access), 1);
`else
        alarm_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(4'hA, 1, 0, 0);
            if (alarm && !access && cnt == 2'd3) alarm_cycles++;
        end
        chk("alarm_hold", alarm_cycles, 100);
        cycle(4'hA, 1, 0, 0);
        cycle(4'h0, 0, 0, 1);
        cycle(4'h0, 0, 0, 1);
`endif

        // Reach ALARM from a known state, then abort it asynchronously.
        do_reset();
        cycle(4'h1, 1, 0, 0);
        cycle(4'h2, 1, 0, 0);
        cycle(4'h3, 1, 0, 0);
        chk("pre_async.alarm", int'(alarm), 1);
        #2 rstn = 1'b0;
        #1;
        chk("async.alarm", int'(alarm), 0);
        chk("async.state", int'(state), 0);
        chk("async.cnt", int'(cnt), 0);
        chk("async.access", int'(access), 0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;

        // MAX_TRY=1 instance: first wrong attempt goes straight to ALARM.
        cycle(4'h3, 1, 0, 0);
        check_model();
        chk("max1.alarm", int'(alarm1), 1);
        chk("max1.state", int'(state1), 2);
        chk("max1.cnt", int'(cnt1), 1);
        chk("max1.fail", int'(fail1), 1);

        // Reset restores the stored password after reprogramming.
        do_reset();
        cycle(4'hA, 1, 0, 0);
        cycle(4'h7, 1, 1, 0);
        cycle(4'h0, 0, 0, 1);
        check_model();
        do_reset();
        cycle(4'hA, 1, 0, 0);
        chk("reset_pass.access", int'(access), 1);
        check_model();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 2 && $urandom_range(0, 15) == 0) begin
                do_reset();
            end else begin
                rp = ($urandom_range(0, 1) == 1) ? 4'(m_pass) : 4'($urandom_range(0, 15));
                cycle(rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 7) == 0));
                check_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
